pipe_skid_buffer: RTL and testbench
===================================

# pipe_skid_buffer

Two-entry elastic pipeline register that sits between two processor stages, on the read side of a stage's state bundle. It accepts one bundle per cycle from the upstream stage through a valid/ready handshake. It presents bundles in order to the downstream stage, absorbs one cycle of downstream back-pressure without dropping data, and supports a synchronous flush for branch/exception squash. A saturating counter reports how many cycles the downstream stage stalled the buffer.

## Interface
- WIDTH, 151, bit width of the stage bundle carried per beat
- CNT_W, 16, width of the stall counter
- clk  input  1  rising-edge clock
- areset  input  1  reset, synchronous, active-high; one clock, no other reset source
- flush  input  1  synchronous squash of all held and incoming beats
- in_valid  input  1  upstream presents a beat
- in_ready  output  1  buffer can accept a beat this cycle
- in_data  input  WIDTH  upstream bundle
- out_valid  output  1  buffer presents a beat
- out_ready  input  1  downstream accepts the beat this cycle
- out_data  output  WIDTH  oldest held bundle
- count  output  2  entries held (0, 1, 2)
- stall_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main entry (main_v, main_d) drives outputs; skid entry (skid_v, skid_d) holds overflow.
- out_valid = main_v; out_data = main_d; in_ready = !skid_v, taken straight from the flop with no combinational path from out_ready.
- Accept: acc = in_valid & in_ready. Release: rel = out_valid & out_ready.
- States, encoded by {skid_v, main_v}:
  - EMPTY (00): acc -> ONE, main_d <= in_data.
  - ONE (01): acc & rel -> ONE, main_d <= in_data. acc & !rel -> FULL, skid_d <= in_data. !acc & rel -> EMPTY. Neither -> hold.
  - FULL (11): acc impossible (in_ready=0). rel -> ONE, main_d <= skid_d. No rel -> hold.
  - 10 is illegal and never reached.
- Order strictly FIFO; no beat duplicated or dropped except by flush.
- count = main_v + skid_v.
- stall_cycles increments when out_valid & !out_ready, saturates at 2^CNT_W-1, and is cleared only by areset; flush does not clear it.
- Priority: areset > flush > normal operation.
  - flush: main_v, skid_v <= 0 next cycle; a beat offered in the same cycle is discarded, even if in_ready=1. Data registers hold their values.
  - A release in the flush cycle still counts as a transfer to downstream.

## Timing
- Reset values after an areset cycle: out_valid=0, in_ready=1, count=0, out_data=0, stall_cycles=0; skid_d=0.
- Latency: a beat accepted at edge n is on out_data with out_valid=1 after edge n, i.e. visible in cycle n+1.
- Throughput: 1 beat/cycle when out_ready is held 1; never any bubble.
- Back-pressure: in_ready falls one cycle after the first stalled acceptance and rises in the cycle after FULL drains to ONE.
- All outputs are registered except out_data, which is the main_d flop directly.
- areset asserted mid-stream (in any state) empties the buffer at the next edge regardless of in_valid, out_ready or flush.

## Test plan
- Reset then stream 0x1..0x8, out_ready=1 -> outputs 0x1..0x8 one per cycle starting the cycle after first acceptance; count stays ≤1; stall_cycles=0.
- Send 0xA, 0xB, 0xC with out_ready=0 for 3 cycles -> 0xA and 0xB held, in_ready=0 and 0xC not accepted, count=2, stall_cycles=2; raise out_ready -> 0xA, 0xB, 0xC delivered in order.
- FULL with flush=1 and in_valid=1 (0xD) -> next cycle count=0, out_valid=0, in_ready=1; 0xD never appears.
- Hold out_valid=1, out_ready=0 for 2^CNT_W+5 cycles -> stall_cycles saturates at 0xFFFF and does not wrap.
- areset asserted while FULL with in_valid=1, out_ready=1 -> next cycle count=0, out_data=0, in_ready=1, stall_cycles=0.
- Random in_valid/out_ready for 10k cycles against a queue model -> exact order match, no loss or duplication; count never reaches 3; state 10 never seen.

Source files
------------

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline register with a skid slot for one cycle of
// downstream back-pressure. It also has a synchronous flush and a saturating
// stall counter.
module pipe_skid_buffer #(
    parameter int unsigned WIDTH = 151,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count,
    output logic [CNT_W-1:0] stall_cycles
);

    // State encoding is {skid_v, main_v}. The value 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q,  main_d;
    logic [WIDTH-1:0]   skid_q,  skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               acc, rel;

    // All outputs come straight from flops. in_ready does not depend on out_ready.
    assign out_valid    = state_q[0];
    assign in_ready     = ~state_q[1];
    assign out_data     = main_q;
    assign count        = {1'b0, state_q[0]} + {1'b0, state_q[1]};
    assign stall_cycles = stall_q;

    assign acc = in_valid & in_ready;
    assign rel = out_valid & out_ready;

    // Compute next state, data moves, and the stall count. Flush overrides the handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (acc && rel) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (rel) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Register all state. Synchronous reset clears both the valid bits and the data.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized self-checking bench for pipe_skid_buffer.
module tb_pipe_skid_buffer;

    localparam int unsigned W = 151;
    localparam int unsigned C = 16;

    logic         clk = 1'b0;
    logic         areset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   count;
    logic [C-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    pipe_skid_buffer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk          (clk),
        .areset       (areset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Advance one cycle. Outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        areset = 1'b0;
        total++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL reset_flags got v=%0b r=%0b c=%0d want v=0 r=1 c=0", out_valid, in_ready, count);
        end
        total++;
        if (out_data !== W'(0) || stall_cycles !== C'(0)) begin
            bad++;
            $display("FAIL reset_regs got data=%0h stall=%0d want data=0 stall=0", out_data, stall_cycles);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = W'(k);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== W'(k) || count !== 2'd1 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_%0d got v=%0b d=%0h c=%0d r=%0b want v=1 d=%0h c=1 r=1",
                         k, out_valid, out_data, count, in_ready, k);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (count !== 2'd0 || out_valid !== 1'b0 || stall_cycles !== C'(0)) begin
            bad++;
            $display("FAIL stream_end got c=%0d v=%0b stall=%0d want c=0 v=0 stall=0", count, out_valid, stall_cycles);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hA);
        tick();
        in_data = W'(32'hB);
        tick();
        total++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full got c=%0d r=%0b want c=2 r=0", count, in_ready);
        end
        in_data = W'(32'hC);
        tick();
        total++;
        if (count !== 2'd2 || out_data !== W'(32'hA) || stall_cycles !== C'(2) || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold got c=%0d d=%0h stall=%0d r=%0b want c=2 d=a stall=2 r=0",
                     count, out_data, stall_cycles, in_ready);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_data !== W'(32'hB) || count !== 2'd1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain_b got d=%0h c=%0d r=%0b want d=b c=1 r=1", out_data, count, in_ready);
        end
        tick();
        total++;
        if (out_data !== W'(32'hC) || out_valid !== 1'b1 || count !== 2'd1) begin
            bad++;
            $display("FAIL bp_drain_c got d=%0h v=%0b c=%0d want d=c v=1 c=1", out_data, out_valid, count);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (count !== 2'd0 || stall_cycles !== C'(2)) begin
            bad++;
            $display("FAIL bp_empty got c=%0d stall=%0d want c=0 stall=2", count, stall_cycles);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'hE);
        tick();
        in_data = W'(32'hF);
        tick();
        // The buffer is now FULL. Offer 0xD while flushing.
        flush = 1'b1; in_data = W'(32'hD);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty got c=%0d v=%0b r=%0b want c=0 v=0 r=1", count, out_valid, in_ready);
        end
        total++;
        if (stall_cycles !== C'(4) || out_data !== W'(32'hE)) begin
            bad++;
            $display("FAIL flush_keep got stall=%0d d=%0h want stall=4 d=e", stall_cycles, out_data);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            bad++;
            $display("FAIL flush_no_d got v=%0b c=%0d want v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_areset_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'(32'h11);
        tick();
        in_data = W'(32'h22);
        tick();
        total++;
        if (count !== 2'd2) begin
            bad++;
            $display("FAIL arst_setup got c=%0d want c=2", count);
        end
        areset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = W'(32'h33);
        tick();
        areset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (count !== 2'd0 || out_data !== W'(0) || in_ready !== 1'b1 ||
            stall_cycles !== C'(0) || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_full got c=%0d d=%0h r=%0b stall=%0d v=%0b want c=0 d=0 r=1 stall=0 v=0",
                     count, out_data, in_ready, stall_cycles, out_valid);
        end
    endtask

    task automatic test_saturation();
        areset = 1'b1; tick(); areset = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = W'(32'h5);
        tick();
        in_valid = 1'b0;
        // From here out_valid=1 and out_ready=0 on every edge.
        for (int i = 0; i < 65534; i++) tick();
        total++;
        if (stall_cycles !== C'(16'hFFFE)) begin
            bad++;
            $display("FAIL sat_before got %0h want fffe", stall_cycles);
        end
        tick();
        total++;
        if (stall_cycles !== C'(16'hFFFF)) begin
            bad++;
            $display("FAIL sat_reach got %0h want ffff", stall_cycles);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (stall_cycles !== C'(16'hFFFF) || out_data !== W'(32'h5)) begin
            bad++;
            $display("FAIL sat_hold got stall=%0h d=%0h want stall=ffff d=5", stall_cycles, out_data);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [C-1:0] m_stall;
        logic         m_acc, m_rel, exp_v;
        logic [W-1:0] exp_d;
        int           errs;
        areset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        areset = 1'b0;
        m_stall = '0;
        errs = 0;
        exp_d = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            exp_v = (q.size() > 0);
            if (exp_v) exp_d = q[0];
            total++;
            if (out_valid !== exp_v || in_ready !== (q.size() < 2) || count !== 2'(q.size()) ||
                stall_cycles !== m_stall || (exp_v && out_data !== exp_d)) begin
                bad++;
                errs++;
                if (errs <= 20)
                    $display("FAIL rand_cyc%0d got v=%0b r=%0b c=%0d stall=%0d d=%0h want v=%0b c=%0d stall=%0d d=%0h",
                             cyc, out_valid, in_ready, count, stall_cycles, out_data,
                             exp_v, q.size(), m_stall, exp_d);
            end
            m_acc = in_valid && (q.size() < 2);
            m_rel = exp_v && out_ready;
            if (exp_v && !out_ready && m_stall != '1) m_stall = m_stall + C'(1);
            tick();
            if (m_rel) void'(q.pop_front());
            if (flush) q.delete();
            else if (m_acc) q.push_back(in_data);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_areset_full();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
